// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//
// Purpose:
//   Runs a multi-step shift by driving an external 1-bit shift datapath once
//   per clock. A request is accepted in IDLE. The operand is then passed
//   through the datapath 'amount' times, with carry chained from step to step
//   and overflow accumulated. The final value is held with done=1 until the
//   consumer acknowledges it.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request, taken only while ready=1
//   a_in, op_in,      operand, op code, step count and initial carry,
//   amount, cin_in    all captured on the acceptance edge
//   ready             high only in IDLE
//   done, ack         result handshake; done holds until ack
//   result, cout,     final operand, last carry, OR of all step overflows,
//   overflow, err     illegal-op flag (all zero unless done=1)
//   sh_abus, sh_op,   operand, op and carry presented to the datapath
//   sh_cin            (all zero outside SHIFT)
//   sh_outbus,        datapath result, carry-out and overflow
//   sh_cout,
//   sh_overflow
// ---------------------------------------------------------------------------
module shift_sequencer #(
    parameter int DATA_W = 16,
    parameter int AMT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a_in,
    input  logic [2:0]        op_in,
    input  logic [AMT_W-1:0]  amount,
    input  logic              cin_in,
    output logic              ready,
    output logic              done,
    input  logic              ack,
    output logic [DATA_W-1:0] result,
    output logic              cout,
    output logic              overflow,
    output logic              err,
    output logic [DATA_W-1:0] sh_abus,
    output logic [2:0]        sh_op,
    output logic              sh_cin,
    input  logic [DATA_W-1:0] sh_outbus,
    input  logic              sh_cout,
    input  logic              sh_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   acc;
    logic [2:0]          op_r;
    logic [AMT_W-1:0]    cnt;
    logic                carry;
    logic                ovf;
    logic                err_r;
    logic                accept;
    logic                step;

    // Legal codes are LSL, LSR, ASR, RLC and RRC (001..101).
    function automatic logic op_legal(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd5);
    endfunction

    // State register. Reset from any state, including mid-operation, lands in
    // IDLE, so an aborted operation never produces a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and all outputs. The result outputs are forced to zero
    // outside DONE, so intermediate accumulator values are never visible.
    // The unused encoding falls through to the default and recovers to IDLE.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        result     = '0;
        cout       = 1'b0;
        overflow   = 1'b0;
        err        = 1'b0;
        sh_abus    = '0;
        sh_op      = 3'b000;
        sh_cin     = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept = 1'b1;
                    if ((amount != '0) && op_legal(op_in)) begin
                        state_next = ST_SHIFT;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                sh_abus = acc;
                sh_op   = op_r;
                sh_cin  = carry;
                step    = 1'b1;
                // cnt==0 cannot occur here; it is treated as the last step
                // for robustness.
                if (cnt <= AMT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                result   = acc;
                cout     = carry;
                overflow = ovf;
                err      = err_r;
                if (ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operation registers. An illegal op loads a zero operand and zero carry,
    // so DONE reports result=0 and cout=0 without special-casing the outputs.
    // Each SHIFT cycle takes the datapath result back unmodified.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            op_r  <= 3'b000;
            cnt   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            err_r <= 1'b0;
        end else if (accept) begin
            op_r <= op_in;
            cnt  <= amount;
            ovf  <= 1'b0;
            if (op_legal(op_in)) begin
                acc   <= a_in;
                carry <= cin_in;
                err_r <= 1'b0;
            end else begin
                acc   <= '0;
                carry <= 1'b0;
                err_r <= 1'b1;
            end
        end else if (step) begin
            acc   <= sh_outbus;
            carry <= sh_cout;
            ovf   <= ovf | sh_overflow;
            cnt   <= cnt - AMT_W'(1);
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
//
// Purpose:
//   Self-checking bench for shift_sequencer. It contains a behavioural model
//   of the 1-bit shift datapath. Directed requests push hand-computed
//   expectations into a scoreboard queue. A monitor pops one entry each time
//   done rises, checks the entry, and acknowledges after a configurable
//   delay.
//
// Ports: none (top-level bench)
// ---------------------------------------------------------------------------
module tb_shift_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a_in;
    logic [2:0]  op_in;
    logic [3:0]  amount;
    logic        cin_in;
    logic        ready;
    logic        done;
    logic        ack;
    logic [15:0] result;
    logic        cout;
    logic        overflow;
    logic        err;
    logic [15:0] sh_abus;
    logic [2:0]  sh_op;
    logic        sh_cin;
    logic [15:0] sh_outbus;
    logic        sh_cout;
    logic        sh_overflow;

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        o;
        logic        e;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_fails   = 0;
    int   ack_delay = 1;

    shift_sequencer #(
        .DATA_W(16),
        .AMT_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a_in       (a_in),
        .op_in      (op_in),
        .amount     (amount),
        .cin_in     (cin_in),
        .ready      (ready),
        .done       (done),
        .ack        (ack),
        .result     (result),
        .cout       (cout),
        .overflow   (overflow),
        .err        (err),
        .sh_abus    (sh_abus),
        .sh_op      (sh_op),
        .sh_cin     (sh_cin),
        .sh_outbus  (sh_outbus),
        .sh_cout    (sh_cout),
        .sh_overflow(sh_overflow)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to measure latency from acceptance to done.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Datapath model. The real block has one quirk: ASR of all-ones yields
    // zero. The model reproduces it so the sequencer's pass-through can be
    // observed.
    always_comb begin
        sh_outbus   = 16'h0000;
        sh_cout     = 1'b0;
        sh_overflow = 1'b0;
        case (sh_op)
            3'b001: begin
                sh_outbus   = {sh_abus[14:0], 1'b0};
                sh_cout     = sh_abus[15];
                sh_overflow = sh_abus[15] ^ sh_abus[14];
            end
            3'b010: begin
                sh_outbus = {1'b0, sh_abus[15:1]};
                sh_cout   = sh_abus[0];
            end
            3'b011: begin
                sh_outbus = (sh_abus == 16'hFFFF) ? 16'h0000 : {sh_abus[15], sh_abus[15:1]};
                sh_cout   = sh_abus[0];
            end
            3'b100: begin
                sh_outbus   = {sh_abus[14:0], sh_cin};
                sh_cout     = sh_abus[15];
                sh_overflow = sh_abus[15] ^ sh_abus[14];
            end
            3'b101: begin
                sh_outbus = {sh_cin, sh_abus[15:1]};
                sh_cout   = sh_abus[0];
            end
            default: begin
                sh_outbus = 16'h0000;
            end
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Issue one request with hand-computed expectations. After the acceptance
    // edge, the inputs are scrambled to show that they are not re-sampled.
    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [3:0] amt,
                                 input logic cin, input logic [15:0] res, input logic c,
                                 input logic o, input logic e, input int lat);
        exp_t ex;
        int   waited;
        waited = 0;
        @(negedge clk);
        while (!ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL ready_timeout: got ready=0 expected ready=1");
            return;
        end
        start   = 1'b1;
        a_in    = a;
        op_in   = op;
        amount  = amt;
        cin_in  = cin;
        ex.res  = res;
        ex.c    = c;
        ex.o    = o;
        ex.e    = e;
        ex.lat  = lat;
        ex.acc_cyc = cyc + 1;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        start  = 1'b0;
        a_in   = ~a;
        op_in  = op ^ 3'b111;
        amount = ~amt;
        cin_in = ~cin;
    endtask

    // Monitor: on each done rise, pop the oldest expectation and check it.
    // The result must stay stable while ack is withheld. After the ack edge,
    // the sequencer must be in IDLE, even if start was high during that edge.
    initial begin
        exp_t ex;
        ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("[TB] FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
                    ack = 1'b1;
                    @(negedge clk);
                    ack = 1'b0;
                end else begin
                    ex = sb.pop_front();
                    checkOutput("result", 32'(result), 32'(ex.res));
                    checkOutput("cout", 32'(cout), 32'(ex.c));
                    checkOutput("overflow", 32'(overflow), 32'(ex.o));
                    checkOutput("err", 32'(err), 32'(ex.e));
                    checkOutput("latency_edges", 32'(cyc - ex.acc_cyc + 1), 32'(ex.lat));
                    checkOutput("sh_op_in_done", 32'(sh_op), 32'd0);
                    checkOutput("ready_in_done", 32'(ready), 32'd0);
                    for (int i = 0; i < ack_delay; i++) begin
                        @(negedge clk);
                        checkOutput("hold_done", 32'(done), 32'd1);
                        checkOutput("hold_result", 32'(result), 32'(ex.res));
                    end
                    ack = 1'b1;
                    @(negedge clk);
                    ack = 1'b0;
                    checkOutput("ready_after_ack", 32'(ready), 32'd1);
                    checkOutput("done_after_ack", 32'(done), 32'd0);
                end
            end
        end
    end

    // Main sequence: reset, directed vectors, held-start handshake,
    // reset abort during SHIFT, drain, summary.
    initial begin
        int waited;
        rst_n  = 1'b0;
        start  = 1'b0;
        a_in   = 16'h0000;
        op_in  = 3'b000;
        amount = 4'd0;
        cin_in = 1'b0;
        #3;
        checkOutput("rst_ready", 32'(ready), 32'd1);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_result", 32'(result), 32'd0);
        checkOutput("rst_sh_abus", 32'(sh_abus), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(3'b011, 16'h8000, 4'd3,  1'b0, 16'hF000, 1'b0, 1'b0, 1'b0, 4);
        applyStimulus(3'b001, 16'h4001, 4'd2,  1'b0, 16'h0004, 1'b1, 1'b1, 1'b0, 3);
        applyStimulus(3'b100, 16'h8000, 4'd2,  1'b1, 16'h0003, 1'b0, 1'b1, 1'b0, 3);
        applyStimulus(3'b110, 16'hABCD, 4'd5,  1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1);
        applyStimulus(3'b010, 16'h1234, 4'd0,  1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1);
        applyStimulus(3'b101, 16'h0001, 4'd1,  1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 2);
        applyStimulus(3'b011, 16'hFFFF, 4'd1,  1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 2);
        applyStimulus(3'b010, 16'h8001, 4'd15, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 16);
        applyStimulus(3'b101, 16'h0003, 4'd3,  1'b1, 16'hE000, 1'b0, 1'b0, 1'b0, 4);
        applyStimulus(3'b000, 16'h1111, 4'd0,  1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1);
        applyStimulus(3'b111, 16'hFFFF, 4'd3,  1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1);
        applyStimulus(3'b001, 16'h0001, 4'd15, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 16);

        // start held high across three operations, with ack delayed by three
        // cycles each time.
        @(negedge clk);
        ack_delay = 3;
        start  = 1'b1;
        a_in   = 16'h00F0;
        op_in  = 3'b010;
        amount = 4'd2;
        cin_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_t ex;
            waited = 0;
            while (!ready && waited < 200) begin
                @(negedge clk);
                waited++;
            end
            if (!ready) begin
                n_checks++;
                n_fails++;
                $display("[TB] FAIL held_ready_timeout: got ready=0 expected ready=1");
            end else begin
                ex.res = 16'h003C;
                ex.c   = 1'b0;
                ex.o   = 1'b0;
                ex.e   = 1'b0;
                ex.lat = 3;
                ex.acc_cyc = cyc + 1;
                sb.push_back(ex);
                @(posedge clk);
                #1;
                if (k == 2) start = 1'b0;
                @(negedge clk);
            end
        end

        // Reset abort five steps into a 15-step ASR.
        waited = 0;
        while (!(ready && sb.size() == 0) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        ack_delay = 1;
        start  = 1'b1;
        a_in   = 16'h8000;
        op_in  = 3'b011;
        amount = 4'd15;
        cin_in = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("mid_sh_op", 32'(sh_op), 32'd3);
        checkOutput("mid_sh_abus", 32'(sh_abus), 32'hFC00);
        checkOutput("mid_ready", 32'(ready), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ready", 32'(ready), 32'd1);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_err", 32'(err), 32'd0);
        checkOutput("abort_result", 32'(result), 32'd0);
        checkOutput("abort_cout", 32'(cout), 32'd0);
        checkOutput("abort_overflow", 32'(overflow), 32'd0);
        checkOutput("abort_sh_abus", 32'(sh_abus), 32'd0);
        checkOutput("abort_sh_op", 32'(sh_op), 32'd0);
        checkOutput("abort_sh_cin", 32'(sh_cin), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("post_abort_ready", 32'(ready), 32'd1);

        waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
